lfsr_checker: RTL

- Receive-side counterpart of the team's 16-bit XNOR random-number generator.
- Consumes the generator's serial bit stream and self-synchronises a local copy of the LFSR from it.
- Declares lock, then counts bit errors. Used to verify random streams crossing between the board and its testbenches, and as a run-time health monitor.

---
 rtl/lfsr_checker.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 16-bit XNOR LFSR generator.
// It fills a local copy of the generator register from the serial stream and
// confirms it against a run of predicted bits. Once locked, it free-runs on its
// own prediction and counts every received bit that disagrees with it.
//
// state  | meaning
// -------+---------------------------------------------------------------
// HUNT   | shifting received bits into the model until 16 are collected
// SYNC   | model loaded; counting consecutive bits that match prediction
// LOCKED | model flywheels on prediction; errors counted per window
module lfsr_checker #(
    parameter int LOCK_COUNT = 32,
    parameter int WINDOW     = 64,
    parameter int LOSS_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear_count,
    output logic        locked,
    output logic        error_pulse,
    output logic [15:0] error_count,
    output logic        stuck,
    output logic [1:0]  state
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(LOSS_LIMIT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        st_q, st_d;
    logic [15:0]   model_q, model_d;
    logic [4:0]    fill_q, fill_d;
    logic [MW-1:0] match_q, match_d;
    logic [WW-1:0] win_q, win_d;
    logic [EW-1:0] werr_q, werr_d;
    logic          pulse_d;
    logic          locked_d;
    logic [15:0]   count_d;
    logic          stuck_d;

    logic          pred;
    logic          miss;
    logic          err_now;
    logic          win_last;
    logic [15:0]   shifted_in;

    // State, model and counter registers; all outputs come straight from flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q        <= HUNT;
            model_q     <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            error_pulse <= 1'b0;
            locked      <= 1'b0;
            error_count <= '0;
            stuck       <= 1'b0;
        end else begin
            st_q        <= st_d;
            model_q     <= model_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            error_pulse <= pulse_d;
            locked      <= locked_d;
            error_count <= count_d;
            stuck       <= stuck_d;
        end
    end

    // Next-state, model update and counter logic for one received bit.
    always_comb begin
        pred       = ~(model_q[15] ^ model_q[14] ^ model_q[12] ^ model_q[3]);
        miss       = bit_in ^ pred;
        shifted_in = {bit_in, model_q[15:1]};
        win_last   = (win_q == WW'(WINDOW - 1));

        st_d     = st_q;
        model_d  = model_q;
        fill_d   = fill_q;
        match_d  = match_q;
        win_d    = win_q;
        werr_d   = werr_q;
        stuck_d  = stuck;
        pulse_d  = 1'b0;
        err_now  = 1'b0;

        if (bit_valid) begin
            case (st_q)
                HUNT: begin
                    model_d = shifted_in;
                    if (fill_q == 5'd15) begin
                        fill_d = '0;
                        // All-ones is the XNOR lock-up value: refill rather than sync on it.
                        if (shifted_in == 16'hFFFF) begin
                            stuck_d = 1'b1;
                        end else begin
                            stuck_d = 1'b0;
                            st_d    = SYNC;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                SYNC: begin
                    model_d = shifted_in;
                    if (miss) begin
                        // The offending bit is already shifted in as the first fill bit.
                        st_d   = HUNT;
                        fill_d = 5'd1;
                    end else if (match_q == MW'(LOCK_COUNT - 1)) begin
                        st_d    = LOCKED;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end
                LOCKED: begin
                    model_d = {pred, model_q[15:1]};
                    win_d   = win_last ? '0 : win_q + WW'(1);
                    err_now = miss;
                    pulse_d = miss;
                    if (miss && (werr_q == EW'(LOSS_LIMIT - 1))) begin
                        st_d    = HUNT;
                        fill_d  = '0;
                        model_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_last) begin
                        werr_d = '0;
                    end else if (miss) begin
                        werr_d = werr_q + EW'(1);
                    end
                end
                default: begin
                    st_d    = HUNT;
                    fill_d  = '0;
                    model_d = '0;
                end
            endcase
        end

        locked_d = (st_d == LOCKED);

        // A clear that coincides with an error leaves that one error counted.
        count_d = error_count;
        if (clear_count) begin
            count_d = {15'd0, err_now};
        end else if (err_now && (error_count != 16'hFFFF)) begin
            count_d = error_count + 16'd1;
        end
    end

    assign state = st_q;

endmodule
